// File: rtl/cpu_types_pkg.sv
// Shared types for the RAM key sequencer: RAM status, sequencer state and key indices.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } seqstate_t;

    localparam int KEY_WR = 0;
    localparam int KEY_RD = 1;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-count debouncer and press-edge pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_n,
    output logic pressed,
    output logic press_evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sample_pressed;

    // Sample the asynchronous active-low key into the clock domain; idle level is released.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n};
        end
    end

    assign sample_pressed = ~sync_q[1];

    // Count consecutive samples that disagree with the accepted level; any agreement restarts.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sample_pressed != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sample_pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounced level, its one-cycle-delayed copy for edge detection, and the stability counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed   = level_q;
    assign press_evt = level_q & ~prev_q;

endmodule

// File: rtl/ram_key_sequencer.sv
// Key-driven RAM command sequencer: one write or read request per debounced press,
// held until the RAM answers with ACCESS, ERROR, or the wait budget runs out.
module ram_key_sequencer
    import cpu_types_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT         = 1024,
    parameter int ADDR_W          = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        key_n,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [31:0]       sw_data,
    input  ramstate_t         ramstate,
    input  logic [31:0]       ramload,
    output logic              ramWEN,
    output logic              ramREN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [31:0]       ramstore,
    output logic [31:0]       disp_data,
    output logic              busy,
    output logic              err
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);

    seqstate_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       store_q, store_d;
    logic [31:0]       disp_q, disp_d;
    logic              err_q, err_d;
    logic [WW-1:0]     wait_q, wait_d;

    logic wr_evt, rd_evt;
    logic wr_pressed, rd_pressed;
    logic unused_levels;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_wr (
        .CLK       (CLK),
        .RST       (RST),
        .key_n     (key_n[KEY_WR]),
        .pressed   (wr_pressed),
        .press_evt (wr_evt)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_rd (
        .CLK       (CLK),
        .RST       (RST),
        .key_n     (key_n[KEY_RD]),
        .pressed   (rd_pressed),
        .press_evt (rd_evt)
    );

    // Held levels are not needed here; only the press pulses drive the sequencer.
    assign unused_levels = wr_pressed ^ rd_pressed;

    // Next-state and datapath decisions; write wins a simultaneous press, and presses
    // arriving outside IDLE are simply not looked at.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        store_d = store_q;
        disp_d  = disp_q;
        err_d   = err_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (wr_evt) begin
                    addr_d  = sw_addr;
                    store_d = sw_data;
                    err_d   = 1'b0;
                    state_d = WRITE;
                end else if (rd_evt) begin
                    addr_d  = sw_addr;
                    err_d   = 1'b0;
                    state_d = READ;
                end
            end
            WRITE, READ: begin
                wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
                if (ramstate == ACCESS) begin
                    if (state_q == READ) begin
                        disp_d = ramload;
                    end
                    state_d = IDLE;
                end else if (ramstate == ERROR) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (wait_q == WAIT_MAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, wait counter and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            store_q <= '0;
            disp_q  <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            disp_q  <= disp_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    assign ramWEN    = (state_q == WRITE);
    assign ramREN    = (state_q == READ);
    assign busy      = (state_q != IDLE);
    assign ramaddr   = addr_q;
    assign ramstore  = store_q;
    assign disp_data = disp_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ram_key_sequencer.sv
// Directed bench for ram_key_sequencer with DEBOUNCE_CYCLES=4 and TIMEOUT=8.
module tb_ram_key_sequencer;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  key_n = 2'b11;
    logic [15:0] sw_addr = '0;
    logic [31:0] sw_data = '0;
    ramstate_t   ramstate = FREE;
    logic [31:0] ramload = '0;
    logic        ramWEN, ramREN, busy, err;
    logic [15:0] ramaddr;
    logic [31:0] ramstore, disp_data;

    int n_checks = 0;
    int n_fail   = 0;

    ram_key_sequencer #(.DEBOUNCE_CYCLES(4), .TIMEOUT(8), .ADDR_W(16)) dut (
        .CLK(CLK), .RST(RST), .key_n(key_n), .sw_addr(sw_addr), .sw_data(sw_data),
        .ramstate(ramstate), .ramload(ramload), .ramWEN(ramWEN), .ramREN(ramREN),
        .ramaddr(ramaddr), .ramstore(ramstore), .disp_data(disp_data),
        .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle(3);
        n_checks++;
        if ({ramWEN, ramREN, busy, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, want 0000", {ramWEN, ramREN, busy, err});
        end
        n_checks++;
        if (ramaddr !== 16'h0 || ramstore !== 32'h0 || disp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h store=%h disp=%h, want zeros", ramaddr, ramstore, disp_data);
        end
        RST = 1'b0;
        idle(2);
    endtask

    task automatic test_clean_write();
        int hi = 0;
        sw_addr = 16'h0003; sw_data = 32'hDEADBEEF; ramstate = FREE;
        key_n[0] = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (ramWEN) hi++;
            if (i == 6) begin
                n_checks++;
                if (ramWEN !== 1'b0) begin n_fail++; $display("FAIL wr_early: ramWEN=%b, want 0", ramWEN); end
            end
            if (i == 7) begin
                n_checks++;
                if (ramWEN !== 1'b1 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL wr_rise: ramWEN=%b busy=%b, want 1 1", ramWEN, busy);
                end
                n_checks++;
                if (ramaddr !== 16'h0003 || ramstore !== 32'hDEADBEEF) begin
                    n_fail++; $display("FAIL wr_latch: addr=%h store=%h, want 0003 deadbeef", ramaddr, ramstore);
                end
            end
            if (i == 9) ramstate = ACCESS;
            if (i == 10) begin
                n_checks++;
                if (ramWEN !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
                    n_fail++; $display("FAIL wr_done: ramWEN=%b busy=%b err=%b, want 0 0 0", ramWEN, busy, err);
                end
                ramstate = FREE;
                key_n[0] = 1'b1;
            end
        end
        n_checks++;
        if (hi != 3) begin n_fail++; $display("FAIL wr_len: ramWEN high %0d cycles, want 3", hi); end
        n_checks++;
        if (ramaddr !== 16'h0003 || ramstore !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wr_hold: addr=%h store=%h, want 0003 deadbeef", ramaddr, ramstore);
        end
        idle(6);
    endtask

    task automatic test_read_capture();
        sw_addr = 16'h0042; ramload = 32'h12345678; ramstate = BUSY;
        key_n[1] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 7) begin
                n_checks++;
                if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 16'h0042) begin
                    n_fail++; $display("FAIL rd_rise: ren=%b wen=%b addr=%h, want 1 0 0042", ramREN, ramWEN, ramaddr);
                end
            end
            if (i == 8) key_n[1] = 1'b1;
            if (i == 9) begin
                n_checks++;
                if (disp_data !== 32'h0 || ramREN !== 1'b1) begin
                    n_fail++; $display("FAIL rd_wait: disp=%h ren=%b, want 00000000 1", disp_data, ramREN);
                end
                ramstate = ACCESS;
            end
            if (i == 10) begin
                n_checks++;
                if (disp_data !== 32'h12345678 || ramREN !== 1'b0 || busy !== 1'b0) begin
                    n_fail++; $display("FAIL rd_capture: disp=%h ren=%b busy=%b, want 12345678 0 0", disp_data, ramREN, busy);
                end
                ramstate = FREE; ramload = 32'hFFFF0000;
            end
        end
        idle(6);
    endtask

    task automatic test_bounce();
        int seen = 0;
        for (int i = 0; i < 20; i++) begin
            key_n[0] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            if (ramWEN || busy) seen++;
        end
        key_n[0] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (ramWEN || busy) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL bounce: request seen %0d cycles, want 0", seen); end
    endtask

    task automatic test_simultaneous();
        int ren_seen = 0;
        sw_addr = 16'h0010; sw_data = 32'hCAFEF00D;
        key_n = 2'b00;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ramREN) ren_seen++;
            if (ramREN && ramWEN) ren_seen += 100;
            if (i == 7) begin
                n_checks++;
                if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin
                    n_fail++; $display("FAIL simul_rise: wen=%b ren=%b, want 1 0", ramWEN, ramREN);
                end
                key_n = 2'b11;
            end
            if (i == 8) ramstate = ACCESS;
            if (i == 9) ramstate = FREE;
        end
        n_checks++;
        if (ren_seen != 0 || busy !== 1'b0 || ramstore !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL simul_drop: ren_cycles=%0d busy=%b store=%h, want 0 0 cafef00d", ren_seen, busy, ramstore);
        end
    endtask

    task automatic test_overlap();
        int ren_seen = 0;
        sw_addr = 16'h0020; sw_data = 32'h0BADC0DE;
        key_n[0] = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (ramREN) ren_seen++;
            if (i == 3) key_n[1] = 1'b0;
            if (i == 11) ramstate = ACCESS;
            if (i == 12) begin
                n_checks++;
                if (ramWEN !== 1'b0 || err !== 1'b0) begin
                    n_fail++; $display("FAIL overlap_done: wen=%b err=%b, want 0 0", ramWEN, err);
                end
                ramstate = FREE;
                key_n = 2'b11;
            end
        end
        n_checks++;
        if (ren_seen != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL overlap_ignore: ren_cycles=%0d busy=%b, want 0 0", ren_seen, busy);
        end
    endtask

    task automatic test_error();
        sw_addr = 16'h0077;
        key_n[1] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 7) key_n[1] = 1'b1;
            if (i == 8) ramstate = ERROR;
            if (i == 9) begin
                n_checks++;
                if (err !== 1'b1 || ramREN !== 1'b0 || busy !== 1'b0) begin
                    n_fail++; $display("FAIL error_exit: err=%b ren=%b busy=%b, want 1 0 0", err, ramREN, busy);
                end
                n_checks++;
                if (disp_data !== 32'h12345678 || ramaddr !== 16'h0077) begin
                    n_fail++; $display("FAIL error_disp: disp=%h addr=%h, want 12345678 0077", disp_data, ramaddr);
                end
                ramstate = FREE;
            end
        end
        idle(4);
    endtask

    task automatic test_timeout();
        int len = 0;
        ramstate = BUSY;
        key_n[1] = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (ramREN) len++;
            if (i == 7) key_n[1] = 1'b1;
            if (i == 14) begin
                n_checks++;
                if (ramREN !== 1'b1) begin n_fail++; $display("FAIL timeout_hold: ren=%b, want 1", ramREN); end
            end
            if (i == 15) begin
                n_checks++;
                if (ramREN !== 1'b0 || err !== 1'b1) begin
                    n_fail++; $display("FAIL timeout_exit: ren=%b err=%b, want 0 1", ramREN, err);
                end
            end
        end
        ramstate = FREE;
        n_checks++;
        if (len != 8) begin n_fail++; $display("FAIL timeout_len: ramREN high %0d cycles, want 8", len); end
    endtask

    task automatic test_err_clear();
        sw_addr = 16'h0005; sw_data = 32'h00000001;
        key_n[0] = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 6) begin
                n_checks++;
                if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: err=%b, want 1", err); end
            end
            if (i == 7) begin
                n_checks++;
                if (err !== 1'b0 || ramWEN !== 1'b1) begin
                    n_fail++; $display("FAIL err_clear: err=%b wen=%b, want 0 1", err, ramWEN);
                end
                key_n[0] = 1'b1;
                ramstate = ACCESS;
            end
            if (i == 8) ramstate = FREE;
        end
    endtask

    task automatic test_reset_mid();
        int wen_seen = 0;
        sw_addr = 16'h00AA; sw_data = 32'h5555AAAA;
        key_n[0] = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 7) begin
                n_checks++;
                if (ramWEN !== 1'b1) begin n_fail++; $display("FAIL rstmid_rise: wen=%b, want 1", ramWEN); end
                key_n[0] = 1'b1;
            end
            if (i == 8) RST = 1'b1;
            if (i == 9) begin
                n_checks++;
                if ({ramWEN, ramREN, busy, err} !== 4'b0000 || ramaddr !== 16'h0 ||
                    ramstore !== 32'h0 || disp_data !== 32'h0) begin
                    n_fail++;
                    $display("FAIL rstmid_values: ctrl=%b addr=%h store=%h disp=%h, want 0000 0 0 0",
                             {ramWEN, ramREN, busy, err}, ramaddr, ramstore, disp_data);
                end
                RST = 1'b0;
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ramWEN || ramREN) wen_seen++;
        end
        n_checks++;
        if (wen_seen != 0) begin n_fail++; $display("FAIL rstmid_reissue: request %0d cycles, want 0", wen_seen); end
    endtask

    initial begin
        test_reset();
        test_clean_write();
        test_read_capture();
        test_bounce();
        test_simultaneous();
        test_overlap();
        test_error();
        test_timeout();
        test_err_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_key_sequencer.md
# ram_key_sequencer

Pushbutton-driven command sequencer that sits directly upstream of the RAM on the FPGA board harness. It debounces the write and read keys, latches address and data from the switches, and drives one RAM request per key press, holding it until the RAM handshakes. It then captures read data into a display register for the downstream hex-display decoders.

## Interface

- DEBOUNCE_CYCLES, 500000: consecutive stable samples required before a key level is accepted (10 ms at 50 MHz).
- TIMEOUT, 1024: maximum cycles a request may wait for ACCESS before it is aborted.
- ADDR_W, 16: RAM address width.

- CLK  in  1  system clock.
- RST  in  1  reset, synchronous and active-high.
- key_n  in  2  raw pushbuttons, active-low, asynchronous. [0] = write, [1] = read.
- sw_addr  in  ADDR_W  switch address.
- sw_data  in  32  switch store data.
- ramstate  in  ramstate_t  RAM status (FREE/BUSY/ACCESS/ERROR) from cpu_types_pkg.
- ramload  in  32  RAM read data.
- ramWEN  out  1  write request.
- ramREN  out  1  read request.
- ramaddr  out  ADDR_W  latched request address.
- ramstore  out  32  latched store data.
- disp_data  out  32  last successfully read word.
- busy  out  1  request in flight.
- err  out  1  sticky flag: last request ended in ERROR or timeout.

## Operation

- Per key: 2-flop synchronizer feeding a debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from the current level. Any bounce restarts the count.
  - A press event is a 1-cycle pulse on a debounced released→pressed transition. Release generates no event.
- FSM states, encoded as seqstate_t: IDLE, WRITE, READ.
  - IDLE:
    - On a write event: latch sw_addr→ramaddr and sw_data→ramstore, clear err, go to WRITE.
    - On a read event: latch sw_addr, clear err, go to READ.
    - Both events in the same cycle: write wins and the read event is dropped.
  - WRITE: ramWEN=1 until exit.
  - READ: ramREN=1 until exit.
  - Exit from WRITE or READ:
    - ramstate==ACCESS: READ captures ramload into disp_data in that cycle. Both go to IDLE.
    - ramstate==ERROR: set err, go to IDLE. disp_data is unchanged.
    - Wait counter reaches TIMEOUT-1 without ACCESS: set err, go to IDLE.
  - Events that arrive while not in IDLE are discarded, not queued.
- busy = (state != IDLE).
- ramaddr and ramstore are stable for the whole request and hold their values after it completes.
- ramWEN and ramREN are never both high.

## Timing

- Reset values: state IDLE, ramWEN=0, ramREN=0, ramaddr=0, ramstore=0, disp_data=0, busy=0, err=0. Debounced levels reset to released; counters reset to 0.
- A reset asserted mid-request drops ramWEN/ramREN at the next edge. No partial capture into disp_data.
- Key latency: let cycle 0 be the first cycle the raw key is sampled low and it stays low. The event pulse occurs in cycle 2+DEBOUNCE_CYCLES. ramWEN/ramREN rise at the following edge.
- Request hold: ramWEN/ramREN are deasserted at the edge after the ACCESS cycle. The minimum request length is 1 cycle (ACCESS in the first cycle).
- The wait counter clears on entry to WRITE/READ and saturates at TIMEOUT-1.
- Back-to-back: a new event is accepted in the first IDLE cycle after completion.

## Structure

- cpu_types_pkg holds:
  - the ramstate_t reference;
  - seqstate_t (IDLE, WRITE, READ);
  - key index constants KEY_WR=0 and KEY_RD=1.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES; ports CLK, RST, key_n, pressed, press_evt) contains the synchronizer, the counter and the edge pulse. It is instantiated twice.
- The top contains the FSM, the wait counter and the output registers.

## Test plan

Bench parameters: DEBOUNCE_CYCLES=4, TIMEOUT=8.

- Clean write: sw_addr=0x0003, sw_data=0xDEADBEEF, key_n[0] held low 10 cycles; ramstate=ACCESS 2 cycles after ramWEN rises. Required: the event 6 cycles after the first low sample; ramWEN high 3 cycles; ramaddr=0x0003, ramstore=0xDEADBEEF; busy falls with ramWEN; err=0.
- Read capture: key_n[1] pressed; ramstate=BUSY 3 cycles then ACCESS with ramload=0x12345678. Required: disp_data=0x12345678 from the edge after ACCESS; ramREN low from that edge.
- Bounce rejection: key_n[0] toggled low/high every 2 cycles for 20 cycles, then released. Required: no event, ramWEN never asserted.
- Simultaneous and overlapping presses: both keys debounce in the same cycle. Required: WRITE only, read dropped. A read pressed during WRITE is ignored.
- Error and timeout:
  - ramstate=ERROR during READ. Required: err=1, disp_data unchanged, return to IDLE.
  - No ACCESS for 8 cycles. Required: err=1 and ramREN drops after exactly 8 request cycles.
  - The next press clears err.
- Reset mid-request: RST high for 1 cycle while ramWEN=1. Required: all outputs at their reset values at the next edge; no request is reissued after RST falls without a new press.
